// File: rtl/adc_fsm_10b_pkg.sv
// adc_fsm_10b_pkg: shared types and constants for the 10-bit SAR controller
package adc_fsm_10b_pkg;
  localparam int WIDTH = 10;
  localparam logic [WIDTH-1:0] MID_CODE = 10'h200;
  localparam logic [WIDTH-1:0] MAX_CODE = 10'h3ff;
  localparam int STEPS_10 = 10;
  localparam int STEPS_12 = 12;
  typedef enum logic [1:0] {IDLE, CONV, CORR1, CORR2} state_t;
endpackage

// File: rtl/adc_fsm_10b_if.sv
// adc_fsm_10b_if: control, comparator and result signals of the SAR controller
interface adc_fsm_10b_if;
  import adc_fsm_10b_pkg::*;
  logic st_conv, sel_12b, cal, comp_in, clkout, sample, adc_done;
  logic [WIDTH-1:0] result, dac_value;
  logic [4:0] dac_msb, dac_lsb;
  modport master (
    output st_conv, sel_12b, cal, comp_in,
    input  clkout, sample, adc_done, result, dac_value, dac_msb, dac_lsb
  );
  modport slave (
    input  st_conv, sel_12b, cal, comp_in,
    output clkout, sample, adc_done, result, dac_value, dac_msb, dac_lsb
  );
endinterface

// File: rtl/adc_fsm_10b_ring_ctrl.sv
// sar_ring_ctrl: busy flag and self-timed comparator fire strobe
module sar_ring_ctrl (
  input  logic clkin,
  input  logic rst,
  input  logic st_conv,
  input  logic fin,
  output logic busy,
  output logic clkout
);
  always_ff @(posedge clkin) busy <= rst ? 1'b0 : ~(busy & fin);
  // while busy every falling done re-fires the comparator, closing the ring
  assign clkout = (st_conv & ~busy) | (busy & ~clkin);
endmodule

// File: rtl/ideal_comparator_10b.sv
// ideal_comparator_10b: behavioural comparator closing the SAR ring in simulation
module ideal_comparator_10b (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vip,
  input  logic [9:0] vin,
  output logic       comp_result,
  output logic       comp_done
);
  logic armed;
  always_ff @(posedge clk) begin
    comp_result <= ~rst & (vip >= vin);
    armed <= ~rst;
  end
  assign comp_done = clk & armed;
endmodule

// File: rtl/adc_fsm_10b.sv
// adc_fsm_10b: self-timed successive-approximation controller for the 10-bit ADC
module adc_fsm_10b
  import adc_fsm_10b_pkg::*;
(
  input logic clkin,
  input logic rst,
  adc_fsm_10b_if.slave bus
);
  state_t state;
  logic [3:0] k, n, ones, ones_n;
  logic [WIDTH-1:0] code, code_n, bump, c1, c2, fin_code;
  logic sel_q, cal_q, busy, fin;
  sar_ring_ctrl u_ring (
    .clkin(clkin), .rst(rst), .st_conv(bus.st_conv), .fin(fin), .busy(busy), .clkout(bus.clkout)
  );
  assign code_n = code | (WIDTH'(bus.comp_in) << k);
  assign bump = (code_n == MAX_CODE) ? MAX_CODE : code_n + WIDTH'(1);
  assign c1 = (bus.comp_in && code != MAX_CODE) ? code + WIDTH'(1) : code;
  assign c2 = (!bus.comp_in && code != '0) ? code - WIDTH'(1) : code;
  assign fin_code = (state == CORR2) ? c2 : code_n;
  assign ones_n = ones + 4'(bus.comp_in);
  // n counts decision edges; the last one of the selected mode ends the conversion
  assign fin = busy && n == (sel_q ? 4'(STEPS_12 - 1) : 4'(STEPS_10 - 1));
  assign bus.dac_msb = bus.dac_value[9:5];
  assign bus.dac_lsb = bus.dac_value[4:0];
  always_ff @(posedge clkin)
    if (rst) begin
      state <= IDLE;
      bus.result <= '0;
      bus.dac_value <= '0;
      bus.adc_done <= 1'b0;
      bus.sample <= 1'b1;
      k <= 4'd9;
      n <= '0;
      ones <= '0;
      code <= '0;
      sel_q <= 1'b0;
      cal_q <= 1'b0;
    end else if (state == IDLE) begin
      state <= CONV;
      bus.sample <= 1'b0;
      bus.adc_done <= 1'b0;
      bus.dac_value <= MID_CODE;
      k <= 4'd9;
      n <= '0;
      ones <= '0;
      code <= '0;
      sel_q <= bus.sel_12b;
      cal_q <= bus.cal;
    end else begin
      n <= n + 4'd1;
      ones <= ones_n;
      if (fin) begin
        state <= IDLE;
        bus.result <= cal_q ? WIDTH'(ones_n) : fin_code;
        bus.adc_done <= 1'b1;
        bus.sample <= 1'b1;
      end else begin
        state <= (state == CONV) ? ((k == 4'd0) ? CORR1 : CONV) : CORR2;
        code <= (state == CONV) ? code_n : c1;
        k <= (state == CONV && k != 4'd0) ? k - 4'd1 : k;
        bus.dac_value <= cal_q ? MID_CODE :
                         (state != CONV) ? c1 :
                         (k == 4'd0) ? bump : code_n | (WIDTH'(1) << (k - 4'd1));
      end
    end
endmodule

// File: tb/tb_adc_fsm_10b.sv
// tb_adc_fsm_10b: delay-closed SAR ring against an ideal comparator, checked by a search model
module tb_adc_fsm_10b;
  import adc_fsm_10b_pkg::*;
  logic clkin = 1'b0, cmp_clk = 1'b0, comp_done, rst = 1'b1;
  logic [9:0] vref = '0;
  adc_fsm_10b_if bus ();
  adc_fsm_10b dut (.clkin(clkin), .rst(rst), .bus(bus));
  ideal_comparator_10b u_cmp (
    .clk(cmp_clk), .rst(1'b0), .vip(vref), .vin(bus.dac_value),
    .comp_result(bus.comp_in), .comp_done(comp_done)
  );
  always @(bus.clkout) cmp_clk <= #3 bus.clkout;
  always @(comp_done) clkin <= #2 comp_done;

  int total = 0, passed = 0, edges = 0;
  int steps = 10, idx = 0, exp_res = 0, last_res = 0;
  bit armed = 1'b0;
  int exp_dac [12];
  int seen [13];
  int lit [10] = '{'h200, 'h100, 'h180, 'h140, 'h160, 'h150, 'h158, 'h154, 'h156, 'h155};

  always @(posedge clkin) edges++;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // trial i keeps the reference bits above the bit under test and sets that bit
  task automatic plan(input int r, input bit s12, input bit c);
    steps = s12 ? 12 : 10;
    for (int i = 0; i < 10; i++)
      exp_dac[i] = c ? 512 : ((r >> (10 - i)) << (10 - i)) + (1 << (9 - i));
    exp_dac[10] = c ? 512 : (r == 1023 ? 1023 : r + 1);
    exp_dac[11] = c ? 512 : r;
    exp_res = c ? (r >= 512 ? steps : 0) : r;
  endtask

  always @(negedge clkin) if (armed) begin
    if (idx < 13) seen[idx] = int'(bus.dac_value);
    chk("dac_value", int'(bus.dac_value), exp_dac[idx < steps ? idx : steps - 1]);
    chk("dac_split", int'({bus.dac_msb, bus.dac_lsb}), exp_dac[idx < steps ? idx : steps - 1]);
    if (idx < steps) begin
      chk("busy_flags", int'({bus.adc_done, bus.sample}), 0);
      chk("result_held", int'(bus.result), last_res);
    end else begin
      chk("done_flags", int'({bus.adc_done, bus.sample}), 3);
      chk("result", int'(bus.result), exp_res);
      last_res = exp_res;
      armed = 1'b0;
    end
    idx++;
  end

  task automatic convert(input int r, input bit s12, input bit c, input bit rep);
    vref = 10'(r);
    bus.sel_12b = s12;
    bus.cal = c;
    plan(r, s12, c);
    idx = 0;
    armed = 1'b1;
    bus.st_conv = 1'b1;
    for (int t = 0; t < 50 && bus.sample; t++) #1;
    bus.st_conv = 1'b0;
    bus.sel_12b = 1'($urandom);
    bus.cal = 1'($urandom);
    if (rep) begin
      for (int t = 0; t < 200 && idx < 4; t++) #1;
      bus.st_conv = 1'b1;
      #3 bus.st_conv = 1'b0;
    end
    for (int t = 0; t < 400 && armed; t++) #1;
    if (armed) begin
      chk("conv_timeout", idx, steps + 1);
      armed = 1'b0;
    end
    #7;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_result"}, int'(bus.result), 0);
    chk({tag, "_dac"}, int'({bus.dac_msb, bus.dac_lsb, bus.dac_value}), 0);
    chk({tag, "_flags"}, int'({bus.adc_done, bus.sample, bus.clkout}), 2);
  endtask

  initial begin
    int e0;
    bus.st_conv = 1'b0;
    bus.sel_12b = 1'b0;
    bus.cal = 1'b0;
    #50 e0 = edges;
    bus.st_conv = 1'b1;
    #40 chk("reset_edges", edges - e0, 1);
    bus.st_conv = 1'b0;
    #20 idle_checks("reset");
    rst = 1'b0;
    #10;
    convert('h155, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) chk("seq_155", seen[i], lit[i]);
    chk("result_155", int'(bus.result), 'h155);
    convert(600, 1'b0, 1'b1, 1'b0);
    chk("cal_10", int'(bus.result), 10);
    convert(600, 1'b1, 1'b1, 1'b0);
    chk("cal_12", int'(bus.result), 12);
    for (int i = 0; i < 12; i++) chk("cal_dac", seen[i], 512);
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 1024; r++) convert(r, 1'(m), 1'b0, 1'($urandom_range(0, 7) == 0));
    convert('h2a7, 1'b0, 1'b0, 1'b1);
    chk("repulse", int'(bus.result), 'h2a7);
    vref = 10'($urandom_range(0, 1023));
    bus.st_conv = 1'b1;
    e0 = edges;
    for (int t = 0; t < 50 && bus.sample; t++) #1;
    bus.st_conv = 1'b0;
    for (int t = 0; t < 200 && edges < e0 + 6; t++) #1;
    rst = 1'b1;
    #40 e0 = edges;
    #40 chk("abort_ring_stopped", edges, e0);
    idle_checks("abort");
    rst = 1'b0;
    last_res = 0;
    #10;
    convert('h0f3, 1'b1, 1'b0, 1'b0);
    chk("after_abort", int'(bus.result), 'h0f3);
    for (int i = 0; i < 200; i++)
      convert(int'($urandom_range(0, 1023)), 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
